axis2fifo: RTL and testbench

Receive-side companion to the accelerator input bridge: accepts one result frame from the HLS accelerator's AXI-Stream master port, buffers up to DEPTH words, then drains them in order through a valid/ready word interface toward the FIFO/CPU side. One frame per `start`. Frame completion is signalled by a `done` pulse. Frames longer than DEPTH are truncated and flagged.

---
 rtl/axis2fifo.sv | 109 ++++++++++
 tb/tb_axis2fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis2fifo.sv
// Receive-side AXI-Stream frame buffer: captures one frame of up to DEPTH words
// after each start, then drains it in order over a valid/ready word port.
module axis2fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tvalid,
  output logic                  m_axis_tready,
  input  logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_valid,
  input  logic                  fifo_ready,
  output logic [CNT_W-1:0]      word_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV    = 3'd1,
    S_DISCARD = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [IDX_W-1:0]      rd_idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic beat, xfer, last_word;

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign m_axis_tready = (state_q == S_RECV) || (state_q == S_DISCARD);
  assign fifo_valid    = (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign word_count    = cnt_q;
  assign overflow      = ovf_q;
  assign fifo_data     = buf_q[rd_idx_q];

  assign beat      = m_axis_tvalid && m_axis_tready;
  assign xfer      = fifo_valid && fifo_ready;
  assign last_word = ({1'b0, rd_idx_q} == (cnt_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RECV;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
          end
        end
        S_RECV: begin
          if (beat) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            cnt_q    <= cnt_q + CNT_W'(1);
            if (m_axis_tlast)
              state_q <= S_DRAIN;
            else if (cnt_q == CNT_W'(DEPTH - 1))
              state_q <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          // Buffer is full: keep the source moving, drop the excess, remember it happened.
          if (beat) begin
            ovf_q <= 1'b1;
            if (m_axis_tlast)
              state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
            if (last_word)
              state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage carries no reset; contents are only read after being written this frame.
  always_ff @(posedge clk) begin
    if (state_q == S_RECV && beat)
      buf_q[wr_idx_q] <= m_axis_tdata;
  end

endmodule

// File: tb/tb_axis2fifo.sv
// Directed bench for axis2fifo: one task per scenario, inline expected-value checks.
module tb_axis2fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] m_axis_tdata = '0;
  logic          m_axis_tvalid = 1'b0;
  logic          m_axis_tready;
  logic          m_axis_tlast = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_ready = 1'b0;
  logic [CNT_W-1:0] word_count;
  logic          overflow;
  logic          done;

  axis2fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .word_count(word_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] stim [8];
  logic [DW-1:0] got [$];
  int done_cnt, done_cyc, acc_cnt, hold_err, fv_cyc, last_acc_cyc;
  bit timed_out;

  // Drives one frame and records what comes out. Cycle 1 is the cycle in which
  // start is held high; everything is driven and sampled on the falling edge.
  task automatic run_frame(input int n, input logic [31:0] gap_pat, input bit toggle_rdy,
                           input bit poke_start, input int abort_after);
    int bi = 0;
    int c = 1;
    bit stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    got.delete();
    done_cnt = 0; done_cyc = 0; acc_cnt = 0; hold_err = 0; fv_cyc = 0; last_acc_cyc = 0;
    timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1;
    forever begin
      @(negedge clk);
      c++;
      start = 1'b0; m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0; fifo_ready = 1'b0;
      if (c > 200) begin timed_out = 1'b1; break; end
      if (done_cyc != 0 && c == done_cyc + 2) break;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (fifo_valid && fv_cyc == 0) fv_cyc = c;
      if (stall_prev && fifo_valid && fifo_data !== data_prev) hold_err++;
      if (m_axis_tready && bi < n) begin
        m_axis_tvalid = !gap_pat[c % 32];
        m_axis_tdata  = stim[bi];
        m_axis_tlast  = (bi == n - 1);
        if (m_axis_tvalid) begin bi++; acc_cnt++; last_acc_cyc = c; end
      end
      if (fifo_valid) begin
        fifo_ready = toggle_rdy ? (c % 2 == 0) : 1'b1;
        if (fifo_ready) got.push_back(fifo_data);
        stall_prev = !fifo_ready;
        data_prev  = fifo_data;
      end else begin
        stall_prev = 1'b0;
      end
      if (poke_start && (m_axis_tready || fifo_valid)) start = 1'b1;
      if (abort_after != 0 && got.size() == abort_after) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (m_axis_tready !== 1'b0 || fifo_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_hs: got tready=%b fvalid=%b done=%b want 0 0 0", m_axis_tready, fifo_valid, done); end
    n_cmp++; if (word_count !== 3'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_cnt: got wc=%0d ovf=%b want 0 0", word_count, overflow); end
    // Reset in the middle of a reception.
    rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; m_axis_tvalid = 1'b1; m_axis_tdata = 32'hDEAD0001;
    @(negedge clk); m_axis_tdata = 32'hDEAD0002;
    @(negedge clk); m_axis_tvalid = 1'b0;
    n_cmp++; if (m_axis_tready !== 1'b1 || word_count !== 3'd2) begin
      n_err++; $display("FAIL midrun_pre: got tready=%b wc=%0d want 1 2", m_axis_tready, word_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (m_axis_tready !== 1'b0 || fifo_valid !== 1'b0 || done !== 1'b0 ||
                 word_count !== 3'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL midrun_rst: got tready=%b fv=%b done=%b wc=%0d ovf=%b want all 0",
                        m_axis_tready, fifo_valid, done, word_count, overflow); end
    @(negedge clk); rst = 1'b0;
    stim[0] = 32'h55;
    run_frame(1, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (got.size() !== 1) begin
      n_err++; $display("FAIL one_beat_size: got %0d want 1", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 32'h55) begin
        n_err++; $display("FAIL one_beat_data: got %0h want 55", got[0]); end
    end
    n_cmp++; if (word_count !== 3'd1 || done_cnt !== 1 || timed_out !== 1'b0) begin
      n_err++; $display("FAIL one_beat_stat: got wc=%0d done_cnt=%0d to=%b want 1 1 0", word_count, done_cnt, timed_out); end
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < 4; i++) stim[i] = 32'hA0 + i;
    run_frame(4, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (got.size() !== 4) begin
      n_err++; $display("FAIL full_size: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== 32'hA0 + i) begin
        n_err++; $display("FAIL full_word%0d: got %0h want %0h", i, got[i], 32'hA0 + i); end
    end
    n_cmp++; if (word_count !== 3'd4 || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_stat: got wc=%0d ovf=%b want 4 0", word_count, overflow); end
    // Start cycle is cycle 1: 4 RECV cycles, 4 DRAIN cycles, done in cycle 10.
    n_cmp++; if (done_cyc !== 10 || done_cnt !== 1) begin
      n_err++; $display("FAIL full_done: got cyc=%0d cnt=%0d want 10 1", done_cyc, done_cnt); end
    n_cmp++; if (fv_cyc !== last_acc_cyc + 1) begin
      n_err++; $display("FAIL full_lat: got first valid cyc %0d want %0d", fv_cyc, last_acc_cyc + 1); end
  endtask

  task automatic test_short_frame;
    stim[0] = 32'h11; stim[1] = 32'h22;
    run_frame(2, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (got.size() !== 2) begin
      n_err++; $display("FAIL short_size: got %0d want 2", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 32'h11 || got[1] !== 32'h22) begin
        n_err++; $display("FAIL short_data: got %0h %0h want 11 22", got[0], got[1]); end
    end
    n_cmp++; if (word_count !== 3'd2 || overflow !== 1'b0 || done_cnt !== 1) begin
      n_err++; $display("FAIL short_stat: got wc=%0d ovf=%b dn=%0d want 2 0 1", word_count, overflow, done_cnt); end
    for (int i = 0; i < 4; i++) stim[i] = 32'hC0 + i;
    run_frame(4, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (got.size() !== 4) begin
      n_err++; $display("FAIL short2_size: got %0d want 4", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 32'hC0 || got[3] !== 32'hC3) begin
        n_err++; $display("FAIL short2_data: got %0h..%0h want c0..c3", got[0], got[3]); end
    end
    n_cmp++; if (word_count !== 3'd4 || done_cyc !== 10) begin
      n_err++; $display("FAIL short2_stat: got wc=%0d cyc=%0d want 4 10", word_count, done_cyc); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 6; i++) stim[i] = i + 1;
    run_frame(6, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (acc_cnt !== 6 || last_acc_cyc !== 7) begin
      n_err++; $display("FAIL ovf_accept: got %0d beats last cyc %0d want 6 7", acc_cnt, last_acc_cyc); end
    n_cmp++; if (got.size() !== 4) begin
      n_err++; $display("FAIL ovf_size: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== i + 1) begin
        n_err++; $display("FAIL ovf_word%0d: got %0h want %0h", i, got[i], i + 1); end
    end
    n_cmp++; if (overflow !== 1'b1 || word_count !== 3'd4 || done_cnt !== 1) begin
      n_err++; $display("FAIL ovf_stat: got ovf=%b wc=%0d dn=%0d want 1 4 1", overflow, word_count, done_cnt); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) stim[i] = 32'hB0 + i;
    run_frame(4, 32'h5A3C_9613, 1'b1, 1'b1, 0);
    n_cmp++; if (got.size() !== 4 || timed_out !== 1'b0) begin
      n_err++; $display("FAIL bp_size: got %0d to=%b want 4 0", got.size(), timed_out); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== 32'hB0 + i) begin
        n_err++; $display("FAIL bp_word%0d: got %0h want %0h", i, got[i], 32'hB0 + i); end
    end
    n_cmp++; if (hold_err !== 0) begin
      n_err++; $display("FAIL bp_hold: got %0d changes while stalled want 0", hold_err); end
    n_cmp++; if (word_count !== 3'd4 || overflow !== 1'b0 || done_cnt !== 1) begin
      n_err++; $display("FAIL bp_stat: got wc=%0d ovf=%b dn=%0d want 4 0 1", word_count, overflow, done_cnt); end
    n_cmp++; if (m_axis_tready !== 1'b0 || fifo_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_idle: got tready=%b fv=%b want 0 0", m_axis_tready, fifo_valid); end
  endtask

  task automatic test_reset_drain;
    for (int i = 0; i < 4; i++) stim[i] = 32'hD0 + i;
    run_frame(4, 32'h0, 1'b0, 1'b0, 2);
    @(posedge clk); #2;
    fifo_ready = 1'b0;
    n_cmp++; if (fifo_valid !== 1'b1 || fifo_data !== 32'hD2) begin
      n_err++; $display("FAIL rd_pre: got fv=%b data=%0h want 1 d2", fifo_valid, fifo_data); end
    rst = 1'b1;
    #1;
    n_cmp++; if (fifo_valid !== 1'b0 || m_axis_tready !== 1'b0 || word_count !== 3'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL rd_rst: got fv=%b tr=%b wc=%0d dn=%b want 0 0 0 0", fifo_valid, m_axis_tready, word_count, done); end
    @(negedge clk); rst = 1'b0;
    run_frame(4, 32'h0, 1'b0, 1'b0, 0);
    n_cmp++; if (got.size() !== 4) begin
      n_err++; $display("FAIL rd_rerun_size: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== 32'hD0 + i) begin
        n_err++; $display("FAIL rd_rerun_word%0d: got %0h want %0h", i, got[i], 32'hD0 + i); end
    end
    n_cmp++; if (done_cyc !== 10 || word_count !== 3'd4) begin
      n_err++; $display("FAIL rd_rerun_stat: got cyc=%0d wc=%0d want 10 4", done_cyc, word_count); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overflow();
    test_back_to_back();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
